// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: decode-stage sequencer that expands an LM/SM instruction
// into one load/store micro-op per set bit of the register list, lowest
// register first, stalling fetch and pipe1 while it runs.
// Optional feature: define LMSM_RA_WB_EN to add the RA write-back (WB) state.
module lm_sm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LIST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       IR,
  input  logic              ir_valid,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall_in,
  output logic              stall_fetch,
  output logic              busy,
  output logic              uop_valid,
  output logic              uop_store,
  output logic [2:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_wb,
  output logic              done
);

`ifdef LMSM_RA_WB_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1} state_t;
`endif

  state_t              state;
  logic [LIST_W-1:0]   mask_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                is_store_q;
  logic [2:0]          ra_q;

  logic                is_lmsm;
  logic                list_empty;
  logic                start;
  logic                last_bit;

  // Index of the lowest set bit; the list is walked R0 upwards.
  function automatic logic [2:0] lowest_idx(input logic [LIST_W-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign is_lmsm    = (IR[15:13] == 3'b011);
  assign list_empty = (IR[LIST_W-1:0] == '0);
  assign start      = ir_valid & is_lmsm & (state == IDLE) & ~stall_in;
  // Exactly one bit left: clearing the lowest bit leaves nothing.
  assign last_bit   = ((mask_q & (mask_q - LIST_W'(1))) == '0);

  // Bits of IR beyond the register list and the opcode fields are not used here.
  logic unused_ir;
  assign unused_ir = ^IR[8:LIST_W];
`ifndef LMSM_RA_WB_EN
  logic unused_ra;
  assign unused_ra = ^ra_q;
`endif

  // Micro-op outputs follow the state; issue and completion are gated by stall_in.
  always_comb begin
    uop_valid = 1'b0;
    uop_store = 1'b0;
    uop_reg   = '0;
    uop_addr  = '0;
    uop_wb    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
`ifndef LMSM_RA_WB_EN
        // An empty list completes on the spot with no transfer.
        done = start & list_empty;
`endif
      end
      ISSUE: begin
        uop_valid = ~stall_in;
        uop_store = is_store_q;
        uop_reg   = lowest_idx(mask_q);
        uop_addr  = addr_q;
`ifndef LMSM_RA_WB_EN
        done      = last_bit & ~stall_in;
`endif
      end
`ifdef LMSM_RA_WB_EN
      WB: begin
        uop_valid = ~stall_in;
        uop_wb    = 1'b1;
        uop_reg   = ra_q;
        uop_addr  = addr_q;
        done      = ~stall_in;
      end
`endif
      default: ;
    endcase
    busy        = (state != IDLE);
    // pipe1 is released in the cycle the final micro-op is accepted.
    stall_fetch = ((state == IDLE) & ir_valid & is_lmsm & ~list_empty) |
                  ((state != IDLE) & ~(done & ~stall_in));
  end

  // FSM and latched instruction context; each accepted transfer retires one list bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask_q     <= '0;
      addr_q     <= '0;
      is_store_q <= 1'b0;
      ra_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q     <= IR[LIST_W-1:0];
            addr_q     <= base_addr;
            is_store_q <= IR[12];
            ra_q       <= IR[11:9];
            if (!list_empty) state <= ISSUE;
`ifdef LMSM_RA_WB_EN
            else             state <= WB;
`endif
          end
        end
        ISSUE: begin
          if (!stall_in) begin
            mask_q <= mask_q & (mask_q - LIST_W'(1));
            addr_q <= addr_q + ADDR_W'(1);
            if (last_bit) begin
`ifdef LMSM_RA_WB_EN
              state <= WB;
`else
              state <= IDLE;
`endif
            end
          end
        end
`ifdef LMSM_RA_WB_EN
        WB: begin
          if (!stall_in) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: scoreboard bench for lm_sm_sequencer.
// Expected micro-ops are queued when an instruction is driven and popped by
// a monitor whenever the sequencer issues one.
module tb_lm_sm_sequencer;

`ifdef LMSM_RA_WB_EN
  localparam int WBX = 1;
`else
  localparam int WBX = 0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] base_addr;
  logic        stall_in;
  logic        stall_fetch;
  logic        busy;
  logic        uop_valid;
  logic        uop_store;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic        uop_wb;
  logic        done;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
    logic        st;
    logic        wb;
    logic        last;
  } uop_t;

  uop_t sb[$];
  int   checks = 0;
  int   errors = 0;

  lm_sm_sequencer #(.ADDR_W(16), .LIST_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .IR          (ir),
    .ir_valid    (ir_valid),
    .base_addr   (base_addr),
    .stall_in    (stall_in),
    .stall_fetch (stall_fetch),
    .busy        (busy),
    .uop_valid   (uop_valid),
    .uop_store   (uop_store),
    .uop_reg     (uop_reg),
    .uop_addr    (uop_addr),
    .uop_wb      (uop_wb),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every issued micro-op must match the head of the scoreboard.
  always @(negedge clk) begin
    uop_t e;
    if (!reset && uop_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_uop", {29'd0, uop_reg}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("uop_reg",   {29'd0, uop_reg}, {29'd0, e.r});
        chk("uop_addr",  {16'd0, uop_addr}, {16'd0, e.a});
        chk("uop_store", {31'd0, uop_store}, {31'd0, e.st});
        chk("uop_wb",    {31'd0, uop_wb}, {31'd0, e.wb});
        chk("uop_done",  {31'd0, done}, {31'd0, e.last});
      end
    end
  end

  // Drive one LM/SM; stall_in is high for len cycles from cycle s (cycle 0 = start cycle).
  task automatic run_instr(input logic [15:0] i_ir, input logic [15:0] i_base,
                           input int s, input int len);
    int   n;
    int   cnt;
    int   dc;
    uop_t e;
    n = 0;
    for (int i = 0; i < 8; i++) if (i_ir[i]) n++;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i_ir[i]) begin
        e.r    = 3'(i);
        e.a    = i_base + 16'(cnt);
        e.st   = i_ir[12];
        e.wb   = 1'b0;
        cnt++;
        e.last = (cnt == n) && (WBX == 0);
        sb.push_back(e);
      end
    end
    if (WBX == 1) begin
      e.r = i_ir[11:9]; e.a = i_base + 16'(n); e.st = 1'b0; e.wb = 1'b1; e.last = 1'b1;
      sb.push_back(e);
    end
    dc = n + ((n > 0) ? len : 0) + WBX;
    ir        = i_ir;
    base_addr = i_base;
    ir_valid  = 1'b1;
    for (int c = 0; c <= dc; c++) begin
      stall_in = (c >= s) && (c < s + len);
      @(negedge clk);
      chk("done",        {31'd0, done}, {31'd0, (c == dc)});
      chk("stall_fetch", {31'd0, stall_fetch}, {31'd0, (n != 0) && (c != dc)});
      chk("busy",        {31'd0, busy}, {31'd0, (c >= 1) && ((n != 0) || (WBX == 1))});
      if (stall_in) begin
        chk("stall_uop_valid", {31'd0, uop_valid}, 32'd0);
        if (sb.size() > 0) chk("stall_uop_reg", {29'd0, uop_reg}, {29'd0, sb[0].r});
      end
      @(posedge clk); #1;
    end
    ir_valid = 1'b0;
    stall_in = 1'b0;
    ir       = 16'h0000;
    @(negedge clk);
    chk("after_busy", {31'd0, busy}, 32'd0);
    chk("after_uop_valid", {31'd0, uop_valid}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    uop_t e;
    reset     = 1'b1;
    ir        = 16'h0000;
    ir_valid  = 1'b0;
    base_addr = 16'h0000;
    stall_in  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",        {31'd0, busy}, 32'd0);
    chk("rst_uop_valid",   {31'd0, uop_valid}, 32'd0);
    chk("rst_stall_fetch", {31'd0, stall_fetch}, 32'd0);
    chk("rst_done",        {31'd0, done}, 32'd0);
    chk("rst_uop_addr",    {16'd0, uop_addr}, 32'd0);
    chk("rst_uop_wb",      {31'd0, uop_wb}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // LM R0,R2 from 0x0100
    run_instr(16'h6A05, 16'h0100, 0, 0);
    // SM single R7 at top of memory, then R0,R7 with address wrap
    run_instr(16'h7E80, 16'hFFFF, 0, 0);
    run_instr(16'h7E81, 16'hFFFF, 0, 0);
    // Full list with a two-cycle stall on the third transfer
    run_instr(16'h60FF, 16'h0400, 3, 2);
    // Empty list
    run_instr(16'h6000, 16'h0500, 0, 0);

    // Non-LM/SM opcode: everything stays 0
    ir = 16'h1234; ir_valid = 1'b1; base_addr = 16'h0600;
    @(negedge clk);
    chk("other_stall_fetch", {31'd0, stall_fetch}, 32'd0);
    chk("other_done",        {31'd0, done}, 32'd0);
    chk("other_uop_valid",   {31'd0, uop_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("other_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // LM opcode with ir_valid low: no start
    ir = 16'h6A05; ir_valid = 1'b0;
    @(negedge clk);
    chk("novalid_stall_fetch", {31'd0, stall_fetch}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("novalid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset after the second transfer of a full-list LM
    for (int i = 0; i < 2; i++) begin
      e.r = 3'(i); e.a = 16'h0200 + 16'(i); e.st = 1'b0; e.wb = 1'b0; e.last = 1'b0;
      sb.push_back(e);
    end
    ir = 16'h60FF; base_addr = 16'h0200; ir_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy",        {31'd0, busy}, 32'd0);
    chk("midrst_uop_valid",   {31'd0, uop_valid}, 32'd0);
    chk("midrst_done",        {31'd0, done}, 32'd0);
    chk("midrst_stall_fetch", {31'd0, stall_fetch}, 32'd1);
    chk("midrst_sb",          sb.size(), 32'd0);
    ir_valid = 1'b0;
    #1;
    chk("midrst_stall_fetch_novalid", {31'd0, stall_fetch}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // New LM after reset starts from R0
    run_instr(16'h6003, 16'h0300, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
